// File: rtl/seq_encrypted_lock_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_encrypted_lock_if
//  Purpose  : Symbol-entry / status bundle between the keypad front end
//             (master) and the sequential lock core (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_encrypted_lock_if #(
  parameter int SYM_W    = 6,
  parameter int MAX_FAIL = 3
);
  localparam int c_fc_w = $clog2(MAX_FAIL + 1);

  logic [SYM_W-1:0]  sym_in;
  logic              sym_valid;
  logic              prog_en;
  logic              clear;
  logic              z;
  logic              fail_pulse;
  logic              locked_out;
  logic [c_fc_w-1:0] fail_cnt;
  logic              busy;

  modport master (
    output sym_in, sym_valid, prog_en, clear,
    input  z, fail_pulse, locked_out, fail_cnt, busy
  );

  modport slave (
    input  sym_in, sym_valid, prog_en, clear,
    output z, fail_pulse, locked_out, fail_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/seq_encrypted_lock.sv
`default_nettype none
// ============================================================================
//  Module   : seq_encrypted_lock
//  Purpose  : Sequential code lock. Compares a strobed sequence of CODE_LEN
//             symbols against a programmable code, opens for OPEN_CYC cycles
//             on a match, counts consecutive failures and locks out for
//             LOCKOUT_CYC cycles after MAX_FAIL of them.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_encrypted_lock #(
  parameter int                          SYM_W       = 6,
  parameter int                          CODE_LEN    = 4,
  parameter int                          MAX_FAIL    = 3,
  parameter int                          LOCKOUT_CYC = 1000,
  parameter int                          OPEN_CYC    = 50,
  parameter logic [CODE_LEN*SYM_W-1:0]   RST_CODE    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_encrypted_lock_if.slave  bus
);

  localparam int c_idx_w = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int c_fc_w  = $clog2(MAX_FAIL + 1);
  localparam int c_tmax  = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int c_tmr_w = (c_tmax > 1) ? $clog2(c_tmax) : 1;

  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(CODE_LEN - 1);
  localparam logic [c_tmr_w-1:0] c_open_load = c_tmr_w'(OPEN_CYC - 1);
  localparam logic [c_tmr_w-1:0] c_lock_load = c_tmr_w'(LOCKOUT_CYC - 1);
  localparam logic [c_fc_w-1:0]  c_max_fail  = c_fc_w'(MAX_FAIL);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_idx_w-1:0] r_idx;
  logic               r_mis;
  logic [SYM_W-1:0]   r_code   [CODE_LEN];
  logic [SYM_W-1:0]   r_shadow [CODE_LEN];
  logic [c_tmr_w-1:0] r_timer;
  logic [c_fc_w-1:0]  r_fail_cnt;
  logic               r_z;
  logic               r_fail_pulse;
  logic               r_locked_out;
  logic               r_busy;

  logic [c_idx_w-1:0] w_idx;
  logic               w_last;
  logic               w_mis;
  logic [c_fc_w-1:0]  w_fail_next;
  logic [SYM_W-1:0]   w_commit [CODE_LEN];

  // Current symbol slot, accumulated mismatch, saturated fail count and the
  // code image that a completing programming sequence will install.
  always_comb begin
    w_idx       = ((r_state == ST_ENTRY) || (r_state == ST_PROG)) ? r_idx : '0;
    w_last      = (w_idx == c_last_idx);
    w_mis       = ((r_state == ST_ENTRY) && r_mis) || (bus.sym_in != r_code[w_idx]);
    w_fail_next = (r_fail_cnt == c_max_fail) ? c_max_fail : r_fail_cnt + 1'b1;
    for (int i = 0; i < CODE_LEN; i++) begin
      w_commit[i] = (c_idx_w'(i) == w_idx) ? bus.sym_in : r_shadow[i];
    end
  end

  // Lock state machine with registered outputs; the code register only ever
  // changes as a whole, from the completed shadow image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_mis        <= 1'b0;
      r_timer      <= '0;
      r_fail_cnt   <= '0;
      r_z          <= 1'b0;
      r_fail_pulse <= 1'b0;
      r_locked_out <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
        r_code[i]   <= RST_CODE[i*SYM_W +: SYM_W];
        r_shadow[i] <= '0;
      end
    end else begin
      r_fail_pulse <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ENTRY: begin
          if (bus.clear) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_mis   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (bus.sym_valid) begin
            if (w_last) begin
              // Every symbol has been consumed; judge the whole sequence.
              r_idx  <= '0;
              r_mis  <= 1'b0;
              r_busy <= 1'b0;
              if (!w_mis) begin
                r_state    <= ST_OPEN;
                r_z        <= 1'b1;
                r_timer    <= c_open_load;
                r_fail_cnt <= '0;
              end else begin
                r_fail_pulse <= 1'b1;
                r_fail_cnt   <= w_fail_next;
                if (w_fail_next == c_max_fail) begin
                  r_state      <= ST_LOCKOUT;
                  r_locked_out <= 1'b1;
                  r_timer      <= c_lock_load;
                end else begin
                  r_state <= ST_IDLE;
                end
              end
            end else begin
              r_state <= ST_ENTRY;
              r_idx   <= w_idx + 1'b1;
              r_mis   <= w_mis;
              r_busy  <= 1'b1;
            end
          end
        end

        ST_OPEN: begin
          if (bus.clear) begin
            r_state <= ST_IDLE;
            r_z     <= 1'b0;
          end else if (bus.sym_valid && bus.prog_en) begin
            r_z         <= 1'b0;
            r_shadow[0] <= bus.sym_in;
            if (w_last) begin
              r_code  <= w_commit;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_PROG;
              r_idx   <= c_idx_w'(1);
              r_busy  <= 1'b1;
            end
          end else if (r_timer == '0) begin
            r_state <= ST_IDLE;
            r_z     <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        ST_PROG: begin
          if (bus.clear) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end else if (bus.sym_valid) begin
            r_shadow[r_idx] <= bus.sym_in;
            if (w_last) begin
              r_code  <= w_commit;
              r_state <= ST_IDLE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        ST_LOCKOUT: begin
          if (r_timer == '0) begin
            r_state      <= ST_IDLE;
            r_locked_out <= 1'b0;
            r_fail_cnt   <= '0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.z          = r_z;
  assign bus.fail_pulse = r_fail_pulse;
  assign bus.locked_out = r_locked_out;
  assign bus.fail_cnt   = r_fail_cnt;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_encrypted_lock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_encrypted_lock
//  Purpose  : Directed plus randomized bench for seq_encrypted_lock against a
//             sequence-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_encrypted_lock;

  localparam int SYM_W       = 6;
  localparam int CODE_LEN    = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 1000;
  localparam int OPEN_CYC    = 50;
  localparam logic [23:0] RST_CODE = {6'h03, 6'h2B, 6'h0A, 6'h15};

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_encrypted_lock_if #(.SYM_W(SYM_W), .MAX_FAIL(MAX_FAIL)) bus_if ();

  seq_encrypted_lock #(
    .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC), .OPEN_CYC(OPEN_CYC), .RST_CODE(RST_CODE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // Reference model: the code as a list of symbols, the symbols typed so far,
  // and remaining open / lockout time.
  logic [5:0] m_code [CODE_LEN];
  logic [5:0] m_entry[$];
  logic [5:0] m_prog_q[$];
  bit         m_prog;
  int         m_open_left;
  int         m_lock_left;
  int         m_fail;
  bit         m_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    logic [23:0] rc;
    rc = RST_CODE;
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = rc[i*6 +: 6];
    m_entry.delete();
    m_prog_q.delete();
    m_prog      = 1'b0;
    m_open_left = 0;
    m_lock_left = 0;
    m_fail      = 0;
    m_pulse     = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [5:0] s, input bit clr, input bit pe);
    bit ok;
    m_pulse = 1'b0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end else if (clr) begin
      m_entry.delete();
      m_prog_q.delete();
      m_prog      = 1'b0;
      m_open_left = 0;
    end else if (m_open_left > 0) begin
      if (v && pe) begin
        m_open_left = 0;
        m_prog      = 1'b1;
        m_prog_q.delete();
        m_prog_q.push_back(s);
      end else begin
        m_open_left--;
      end
    end else if (m_prog) begin
      if (v) begin
        m_prog_q.push_back(s);
        if (m_prog_q.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_prog_q[i];
          m_prog_q.delete();
          m_prog = 1'b0;
        end
      end
    end else if (v) begin
      m_entry.push_back(s);
      if (m_entry.size() == CODE_LEN) begin
        ok = 1'b1;
        for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
        m_entry.delete();
        if (ok) begin
          m_open_left = OPEN_CYC;
          m_fail      = 0;
        end else begin
          m_pulse = 1'b1;
          if (m_fail < MAX_FAIL) m_fail++;
          if (m_fail == MAX_FAIL) m_lock_left = LOCKOUT_CYC;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("z",          32'(bus_if.z),          32'(m_open_left > 0));
    check("fail_pulse", 32'(bus_if.fail_pulse), 32'(m_pulse));
    check("locked_out", 32'(bus_if.locked_out), 32'(m_lock_left > 0));
    check("fail_cnt",   32'(bus_if.fail_cnt),   32'(m_fail));
    check("busy",       32'(bus_if.busy),       32'((m_entry.size() > 0) || m_prog));
  endtask

  task automatic cycle(input bit v, input logic [5:0] s, input bit clr, input bit pe);
    bus_if.sym_valid = v;
    bus_if.sym_in    = s;
    bus_if.clear     = clr;
    bus_if.prog_en   = pe;
    @(posedge clk);
    model_step(v, s, clr, pe);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'h00, 1'b0, 1'b0);
  endtask

  // Types a full code (symbol 0 in the LSBs), one idle cycle between strobes.
  task automatic enter(input logic [23:0] code, input bit pe);
    for (int i = 0; i < CODE_LEN; i++) begin
      cycle(1'b1, code[i*6 +: 6], 1'b0, pe);
      cycle(1'b0, 6'h00, 1'b0, 1'b0);
    end
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic reset_mid(input string tag);
    bus_if.sym_valid = 1'b0;
    bus_if.clear     = 1'b0;
    bus_if.prog_en   = 1'b0;
    rst = 1'b1;
    #1;
    check({tag, "_z"},          32'(bus_if.z),          32'd0);
    check({tag, "_pulse"},      32'(bus_if.fail_pulse), 32'd0);
    check({tag, "_locked_out"}, 32'(bus_if.locked_out), 32'd0);
    check({tag, "_fail_cnt"},   32'(bus_if.fail_cnt),   32'd0);
    check({tag, "_busy"},       32'(bus_if.busy),       32'd0);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  logic [23:0] wrong_code;
  logic [23:0] new_code;
  logic [23:0] other_code;
  logic [5:0]  r_sym;
  bit          r_v, r_clr, r_pe;

  initial begin
    wrong_code = {6'h03, 6'h2A, 6'h0A, 6'h15};
    new_code   = {6'h04, 6'h03, 6'h02, 6'h01};
    other_code = {6'h3F, 6'h3E, 6'h3D, 6'h3C};

    rst              = 1'b1;
    bus_if.sym_in    = '0;
    bus_if.sym_valid = 1'b0;
    bus_if.prog_en   = 1'b0;
    bus_if.clear     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    // Correct default code opens for OPEN_CYC cycles.
    enter(RST_CODE, 1'b0);
    idle(OPEN_CYC + 5);

    // Third symbol wrong: one fail pulse, count 1.
    enter(wrong_code, 1'b0);
    idle(3);

    // Two more failures lock out; correct code during lockout is ignored.
    enter(wrong_code, 1'b0);
    enter(wrong_code, 1'b0);
    enter(RST_CODE, 1'b0);
    idle(LOCKOUT_CYC);
    enter(RST_CODE, 1'b0);
    idle(OPEN_CYC + 5);

    // Reprogram while open, old code fails, new one opens.
    enter(RST_CODE, 1'b0);
    idle(2);
    enter(new_code, 1'b1);
    idle(2);
    enter(RST_CODE, 1'b0);
    enter(new_code, 1'b0);
    // Second programming attempt aborted by clear keeps the new code.
    cycle(1'b1, other_code[5:0], 1'b0, 1'b1);
    cycle(1'b1, other_code[11:6], 1'b0, 1'b0);
    cycle(1'b0, 6'h00, 1'b1, 1'b0);
    enter(new_code, 1'b0);
    idle(OPEN_CYC + 5);

    // Partial entry discarded by clear, then full code opens.
    cycle(1'b1, new_code[5:0], 1'b0, 1'b0);
    cycle(1'b1, new_code[11:6], 1'b0, 1'b0);
    cycle(1'b1, 6'h15, 1'b1, 1'b0);
    enter(new_code, 1'b0);
    idle(OPEN_CYC + 5);

    // Reset mid-entry restores the reset code.
    cycle(1'b1, new_code[5:0], 1'b0, 1'b0);
    reset_mid("rst_entry");
    enter(RST_CODE, 1'b0);
    idle(OPEN_CYC + 5);

    // Reset mid-lockout.
    enter(wrong_code, 1'b0);
    enter(wrong_code, 1'b0);
    enter(wrong_code, 1'b0);
    idle(100);
    reset_mid("rst_lockout");
    idle(3);

    // Randomized traffic biased toward the currently stored code.
    for (int n = 0; n < 5000; n++) begin
      r_v   = ($urandom % 3) == 0;
      r_clr = ($urandom % 50) == 0;
      r_pe  = ($urandom % 8) == 0;
      if (($urandom % 5) != 0 && !m_prog && m_entry.size() < CODE_LEN)
        r_sym = m_code[m_entry.size()];
      else
        r_sym = 6'($urandom);
      cycle(r_v, r_sym, r_clr, r_pe);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_encrypted_lock.md
Name: seq_encrypted_lock

Overview:
- Sequential, parametrised successor to the team's combinational 6-input encrypted lock.
- Instead of one static 6-bit pattern, the user enters a sequence of CODE_LEN symbols, each SYM_W bits wide, on a strobed input.
- The block compares the sequence against a programmable stored code. It also counts failed attempts and locks out after MAX_FAIL failures for LOCKOUT_CYC cycles.
- It sits between the keypad/switch debouncer and the door actuator driver.

Parameters:
- SYM_W, 6: width of one entered symbol; matches the original six switch inputs.
- CODE_LEN, 4: number of symbols per code, at least 1.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout, at least 1.
- LOCKOUT_CYC, 1000: lockout duration in clock cycles, at least 1.
- OPEN_CYC, 50: cycles the unlock output stays high after a correct code, at least 1.
- RST_CODE, 0: reset value of the stored code, width CODE_LEN*SYM_W; symbol 0 is in the LSBs.

Ports:
- clk, input, 1: system clock; all state on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- sym_in, input, SYM_W: entered symbol.
- sym_valid, input, 1: one-cycle strobe; sym_in is sampled when this is high.
- prog_en, input, 1: when high while OPEN, the next CODE_LEN strobed symbols become the new code.
- clear, input, 1: aborts the current entry and returns to IDLE. It does not change the fail count and does not end a lockout.
- z, output, 1: unlock. High for OPEN_CYC cycles after a correct code.
- fail_pulse, output, 1: one-cycle pulse on each wrong completed code.
- locked_out, output, 1: high during lockout.
- fail_cnt, output, clog2(MAX_FAIL+1): current count of consecutive failures.
- busy, output, 1: high while a code entry is in progress.

Behaviour:
- Reset: state IDLE; z=0, fail_pulse=0, locked_out=0, fail_cnt=0, busy=0; symbol index=0; mismatch flag=0; code register=RST_CODE. The reset is asynchronous and takes effect mid-entry, mid-open, or mid-lockout.
- States are IDLE, ENTRY, OPEN, PROG and LOCKOUT.
- IDLE:
  - sym_valid starts an entry. The symbol is compared to code[0], index becomes 1, the mismatch flag is set if the symbol differs, and the state goes to ENTRY.
  - If CODE_LEN=1, the block goes directly to the evaluation step.
- ENTRY:
  - busy=1.
  - Each sym_valid compares sym_in to code[index] and ORs any difference into the mismatch flag. All CODE_LEN symbols are always consumed; there is no early reject, to avoid a timing leak.
  - On the CODE_LEN-th symbol, evaluation happens in the same edge:
    - Match: go to OPEN, z=1 from the next cycle, fail_cnt=0.
    - Mismatch: fail_pulse=1 for one cycle and fail_cnt increments. If the new count equals MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- Latency: z rises exactly 1 cycle after the clock edge that samples the last correct symbol.
- OPEN:
  - z=1 for exactly OPEN_CYC cycles, then IDLE.
  - sym_valid is ignored unless prog_en=1. With prog_en=1, that symbol is written to a shadow slot 0 and the state goes to PROG; z drops.
- PROG:
  - Collects the remaining CODE_LEN-1 symbols into the shadow register.
  - On the last symbol, the shadow is copied atomically to the code register and the state goes to IDLE.
  - clear in PROG discards the shadow; the code is unchanged.
- LOCKOUT:
  - locked_out=1, fail_cnt is held at MAX_FAIL, and sym_valid and clear are ignored.
  - After exactly LOCKOUT_CYC cycles: IDLE, fail_cnt=0, locked_out=0.
- clear and sym_valid in the same cycle: clear wins and the symbol is dropped.
- fail_cnt saturates and never wraps.
- Timers and counters are sized with clog2 and have no wrap-around.

Test Plan:
1. Defaults, with RST_CODE set to {0x3,0x2B,0x0A,0x15} (symbol 0 = 0x15). Enter 0x15, 0x0A, 0x2B, 0x03 -> z high 1 cycle after the 4th strobe, for 50 cycles; fail_cnt=0.
2. Enter 0x15, 0x0A, 0x2A, 0x03 (third symbol wrong) -> no z; fail_pulse for 1 cycle only after the 4th strobe; fail_cnt=1; busy high throughout.
3. Three wrong codes -> after the third, locked_out=1 for 1000 cycles. A correct code entered during lockout is ignored. Afterwards fail_cnt=0 and the correct code opens.
4. Correct code, then in OPEN enter prog_en with 0x01, 0x02, 0x03, 0x04 -> the old code now fails and 0x01..0x04 opens. A clear during a second programming attempt leaves 0x01..0x04 valid.
5. Enter 2 symbols, pulse clear, then enter the full correct code -> opens; the partial entry is discarded.
6. Assert rst mid-entry and mid-lockout -> all outputs 0 immediately without a clock edge; the code reverts to RST_CODE.
